stream_mux_4x1: RTL and testbench

- Four-to-one streaming multiplexer. It collects beats from four valid/ready input channels (a, b, c, d) and merges them onto one valid/ready output.
- It is the gathering counterpart of the team's 1x4 demux. It arbitrates among the requesting channels and registers the winning beat.
- Each output beat carries a source code, out_sel. This code uses the same sel encoding the 1x4 demux uses for routing, so it can drive a demux directly to steer responses back to the originating channel.

---
 rtl/stream_mux_4x1.sv | 140 ++++++++++++++
 tb/tb_stream_mux_4x1.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_4x1.sv
// -----------------------------------------------------------------------------
// stream_mux_4x1
//
// Purpose:
//   Four-to-one valid/ready stream multiplexer. It arbitrates among channels
//   a, b, c and d, and registers the winning beat into a single output stage.
//   Each output beat carries a source code (out_sel) in the 1x4 demux sel
//   encoding: a=00, b=10, c=01, d=11. That code can steer responses straight
//   back to the originating channel.
//
// Configuration macro:
//   STREAM_MUX_RR_EN  defined   -> round-robin arbitration. A pointer moves to
//                                  the channel after the last winner.
//                     undefined -> fixed priority a > b > c > d, with no
//                                  pointer register.
//
// Ports:
//   clk                    in   clock, rising edge
//   rst                    in   asynchronous active-high reset
//   {a,b,c,d}_valid        in   channel has a beat
//   {a,b,c,d}_data [DW]    in   channel payload
//   {a,b,c,d}_ready        out  channel beat accepted this cycle (combinational)
//   out_valid              out  registered output beat present
//   out_data [DW]          out  registered payload
//   out_sel [2]            out  registered source code
//   out_ready              in   downstream accepts the beat
// -----------------------------------------------------------------------------
module stream_mux_4x1 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic          b_valid,
  input  logic          c_valid,
  input  logic          d_valid,
  input  logic [DW-1:0] a_data,
  input  logic [DW-1:0] b_data,
  input  logic [DW-1:0] c_data,
  input  logic [DW-1:0] d_data,
  output logic          a_ready,
  output logic          b_ready,
  output logic          c_ready,
  output logic          d_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_sel,
  input  logic          out_ready
);

  // Internal channel index: 0=a, 1=b, 2=c, 3=d.
  logic [3:0]    w_req;
  logic [DW-1:0] w_data [4];
  logic [3:0]    w_ready;
  logic [1:0]    w_ptr;
  logic          w_load;
  logic          w_found;
  logic [1:0]    w_gnt;
  logic          w_xfer;

  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [1:0]    r_out_sel;

  assign w_req     = {d_valid, c_valid, b_valid, a_valid};
  assign w_data[0] = a_data;
  assign w_data[1] = b_data;
  assign w_data[2] = c_data;
  assign w_data[3] = d_data;

  // The output stage can accept a beat when it is empty or being drained now.
  assign w_load = ~r_out_valid | out_ready;

`ifdef STREAM_MUX_RR_EN
  logic [1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 2'd0;
    end else if (w_xfer) begin
      r_ptr <= w_gnt + 2'd1;  // the 2-bit wrap takes d back to a
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = 2'd0;
`endif

  // Cyclic scan from the pointer. The first requesting channel wins.
  always_comb begin
    logic [1:0] v_cand;
    w_found = 1'b0;
    w_gnt   = 2'd0;
    v_cand  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      v_cand = w_ptr + 2'(k);
      if (!w_found && w_req[v_cand]) begin
        w_found = 1'b1;
        w_gnt   = v_cand;
      end
    end
  end

  // rst gates the grant, so no input beat is accepted while reset is held.
  assign w_xfer = w_load & w_found & ~rst;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ready
      assign w_ready[gi] = w_xfer & (w_gnt == 2'(gi));
    end
  endgenerate

  assign a_ready = w_ready[0];
  assign b_ready = w_ready[1];
  assign c_ready = w_ready[2];
  assign d_ready = w_ready[3];

  // Output register. A new beat overrides a drain in the same cycle, so the
  // stream has no bubble. On a drain only, data and sel keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 2'b00;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data[w_gnt];
      r_out_sel   <= {w_gnt[0], w_gnt[1]};  // index bit-reversed into the demux code
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_4x1.sv
module tb_stream_mux_4x1;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          a_valid, b_valid, c_valid, d_valid;
  logic [DW-1:0] a_data, b_data, c_data, d_data;
  logic          a_ready, b_ready, c_ready, d_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_ready;

  int checks;
  int errors;

  stream_mux_4x1 #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .c_valid   (c_valid),
    .d_valid   (d_valid),
    .a_data    (a_data),
    .b_data    (b_data),
    .c_data    (c_data),
    .d_data    (d_data),
    .a_ready   (a_ready),
    .b_ready   (b_ready),
    .c_ready   (c_ready),
    .d_ready   (d_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rdy();
    return {d_ready, c_ready, b_ready, a_ready};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valids(input logic [3:0] v);
    {d_valid, c_valid, b_valid, a_valid} = v;
  endtask

  // Pulse reset between edges, then realign to just after a rising edge.
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    a_data = 8'h11; b_data = 8'h22; c_data = 8'h33; d_data = 8'h44;
    set_valids(4'b1111);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b0 || rdy() !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold: out_valid=%b ready=%b, required 0/0000", out_valid, rdy());
      end
      tick();
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy() !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: ready=%b, required 0001", rdy());
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || out_sel !== 2'b00) begin
      errors++;
      $display("FAIL reset_first_beat: v=%b d=%h s=%b, required 1/11/00", out_valid, out_data, out_sel);
    end
    $display("beat: sel=%b data=%h", out_sel, out_data);
    set_valids(4'b0000);
  endtask

  task automatic test_single_c();
    c_data = 8'h5A;
    set_valids(4'b0100);
    #1;
    checks++;
    if (rdy() !== 4'b0100) begin
      errors++;
      $display("FAIL single_c_ready: ready=%b, required 0100", rdy());
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || out_sel !== 2'b01) begin
      errors++;
      $display("FAIL single_c_beat: v=%b d=%h s=%b, required 1/5a/01", out_valid, out_data, out_sel);
    end
    $display("beat: sel=%b data=%h", out_sel, out_data);
    set_valids(4'b0000);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h5A || out_sel !== 2'b01) begin
      errors++;
      $display("FAIL single_c_drain: v=%b d=%h s=%b, required 0/5a/01", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_all_valid();
    logic [1:0]    sel_tab [4];
    logic [DW-1:0] dat_tab [4];
    int            exp_idx [5];
    sel_tab = '{2'b00, 2'b10, 2'b01, 2'b11};
    dat_tab = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
`ifdef STREAM_MUX_RR_EN
    exp_idx = '{0, 1, 2, 3, 0};
`else
    exp_idx = '{0, 0, 0, 0, 0};
`endif
    pulse_reset();
    a_data = 8'hA0; b_data = 8'hA1; c_data = 8'hA2; d_data = 8'hA3;
    out_ready = 1'b1;
    set_valids(4'b1111);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rdy() !== (4'b0001 << exp_idx[i])) begin
        errors++;
        $display("FAIL all_valid_grant[%0d]: ready=%b, required %b", i, rdy(), 4'b0001 << exp_idx[i]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== dat_tab[exp_idx[i]] || out_sel !== sel_tab[exp_idx[i]]) begin
        errors++;
        $display("FAIL all_valid_beat[%0d]: v=%b d=%h s=%b, required 1/%h/%b", i, out_valid, out_data,
                 out_sel, dat_tab[exp_idx[i]], sel_tab[exp_idx[i]]);
      end
      $display("beat: sel=%b data=%h", out_sel, out_data);
    end
    set_valids(4'b0000);
  endtask

  // Runs after test_all_valid. The held beat is a's (A0, 00), and the next
  // winner among b and d is b both with round-robin (pointer at b) and with
  // fixed priority.
  task automatic test_hold();
    out_ready = 1'b0;
    b_data = 8'hB5; d_data = 8'hD7;
    set_valids(4'b1010);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rdy() !== 4'b0000) begin
        errors++;
        $display("FAIL hold_ready[%0d]: ready=%b, required 0000", i, rdy());
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA0 || out_sel !== 2'b00) begin
        errors++;
        $display("FAIL hold_stable[%0d]: v=%b d=%h s=%b, required 1/a0/00", i, out_valid, out_data, out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (rdy() !== 4'b0010) begin
      errors++;
      $display("FAIL hold_release_grant: ready=%b, required 0010", rdy());
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB5 || out_sel !== 2'b10) begin
      errors++;
      $display("FAIL hold_release_beat: v=%b d=%h s=%b, required 1/b5/10", out_valid, out_data, out_sel);
    end
    $display("beat: sel=%b data=%h", out_sel, out_data);
    set_valids(4'b0000);
    tick();
  endtask

  task automatic test_drain_ptr();
    pulse_reset();
    out_ready = 1'b1;
    a_data = 8'h3C;
    set_valids(4'b0001);
    #1;
    checks++;
    if (rdy() !== 4'b0001) begin
      errors++;
      $display("FAIL drain_a_ready: ready=%b, required 0001", rdy());
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
      errors++;
      $display("FAIL drain_a_beat: v=%b d=%h, required 1/3c", out_valid, out_data);
    end
    $display("beat: sel=%b data=%h", out_sel, out_data);
    set_valids(4'b0000);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h3C || out_sel !== 2'b00) begin
      errors++;
      $display("FAIL drain_empty: v=%b d=%h s=%b, required 0/3c/00", out_valid, out_data, out_sel);
    end
    // The pointer can only be seen through the next arbitration.
    set_valids(4'b1111);
    #1;
    checks++;
`ifdef STREAM_MUX_RR_EN
    if (rdy() !== 4'b0010) begin
      errors++;
      $display("FAIL drain_ptr_next: ready=%b, required 0010", rdy());
    end
`else
    if (rdy() !== 4'b0001) begin
      errors++;
      $display("FAIL drain_ptr_next: ready=%b, required 0001", rdy());
    end
`endif
    tick();
    set_valids(4'b0000);
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    a_data = 8'h99;
    set_valids(4'b0001);
    tick();
    set_valids(4'b0000);
    out_ready = 1'b0;
    b_data = 8'h77;
    b_valid = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h99) begin
      errors++;
      $display("FAIL async_pre_hold: v=%b d=%h, required 1/99", out_valid, out_data);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || rdy() !== 4'b0000) begin
      errors++;
      $display("FAIL async_immediate: v=%b ready=%b, required 0/0000", out_valid, rdy());
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_in_reset: v=%b, required 0", out_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (rdy() !== 4'b0010) begin
      errors++;
      $display("FAIL async_release_grant: ready=%b, required 0010", rdy());
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h77 || out_sel !== 2'b10) begin
      errors++;
      $display("FAIL async_release_beat: v=%b d=%h s=%b, required 1/77/10", out_valid, out_data, out_sel);
    end
    $display("beat: sel=%b data=%h", out_sel, out_data);
    b_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_no_dup: v=%b, required 0", out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    out_ready = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0;
    a_data = '0; b_data = '0; c_data = '0; d_data = '0;
    test_reset();
    test_single_c();
    test_all_valid();
    test_hold();
    test_drain_ptr();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
